inst_fetcher: RTL and testbench

Instruction fetch stage between the PC register and the instruction queue. Each cycle it is free, it reads the current PC, looks it up in a small direct-mapped instruction cache, and fetches the word from the memory controller on a miss. It returns the instruction to the PC register in a one-cycle ask handshake so the PC register can predict the next PC. It then pushes the instruction, its PC and the PC register's jump prediction into the instruction queue.

---
 rtl/inst_fetcher.sv | 125 ++++++++++++
 tb/tb_inst_fetcher.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: PC lookup in a direct-mapped I-cache, memory fill on miss, ask/push handshake.
// The cache exists only when FETCHER_ICACHE_EN is defined; otherwise every fetch is serviced by memory.
module inst_fetcher #(
  parameter int ICACHE_INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        has_misbranch,
  input  logic [31:0] in_pc,
  input  logic        in_has_jump,
  output logic [31:0] out_inst,
  output logic        out_has_ask,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        iq_full,
  output logic        iq_valid,
  output logic [31:0] iq_inst,
  output logic [31:0] iq_pc,
  output logic        iq_pred_jump
);
  typedef enum logic [1:0] {IDLE, MISS, ASK, PUSH} state_t;

  state_t      state;
  logic [31:0] cur_pc;
  logic        hit;
  logic [31:0] hit_data;

  if (ICACHE_INDEX_BITS < 1 || ICACHE_INDEX_BITS > 20) begin : g_bad_index
    $error("inst_fetcher: ICACHE_INDEX_BITS out of range");
  end

`ifdef FETCHER_ICACHE_EN
  localparam int LINES = 1 << ICACHE_INDEX_BITS;
  localparam int TAG_W = 30 - ICACHE_INDEX_BITS;

  logic [LINES-1:0]             line_valid;
  logic [TAG_W-1:0]             line_tag  [LINES];
  logic [31:0]                  line_data [LINES];
  logic [ICACHE_INDEX_BITS-1:0] rd_idx;
  logic [ICACHE_INDEX_BITS-1:0] wr_idx;
  logic                         fill;

  assign rd_idx   = in_pc[ICACHE_INDEX_BITS+1:2];
  assign wr_idx   = cur_pc[ICACHE_INDEX_BITS+1:2];
  assign hit      = line_valid[rd_idx] && (line_tag[rd_idx] == in_pc[31:ICACHE_INDEX_BITS+2]);
  assign hit_data = line_data[rd_idx];
  // A response racing a flush is dropped, so it must not reach the array either.
  assign fill     = rdy && !has_misbranch && (state == MISS) && mem_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      line_valid <= '0;
    end else if (fill) begin
      line_valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      line_tag[wr_idx]  <= cur_pc[31:ICACHE_INDEX_BITS+2];
      line_data[wr_idx] <= mem_data;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_pc      <= '0;
      out_inst    <= '0;
      out_has_ask <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
    end else if (rdy) begin
      if (has_misbranch) begin
        state       <= IDLE;
        out_has_ask <= 1'b0;
        mem_req     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!iq_full) begin
              cur_pc <= in_pc;
              if (hit) begin
                out_inst    <= hit_data;
                out_has_ask <= 1'b1;
                state       <= ASK;
              end else begin
                mem_req  <= 1'b1;
                mem_addr <= in_pc;
                state    <= MISS;
              end
            end
          end
          MISS: begin
            if (mem_done) begin
              out_inst    <= mem_data;
              out_has_ask <= 1'b1;
              mem_req     <= 1'b0;
              state       <= ASK;
            end
          end
          ASK: begin
            out_has_ask <= 1'b0;
            state       <= PUSH;
          end
          PUSH: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Queue space was checked in IDLE and nothing else pushes, so PUSH needs no iq_full test.
  assign iq_valid     = (state == PUSH) && rdy && !has_misbranch;
  assign iq_inst      = out_inst;
  assign iq_pc        = cur_pc;
  assign iq_pred_jump = in_has_jump;
endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: directed fetch table, multi-cycle corner sequences, and a randomized run
// against a transaction-level model (word memory, direct-mapped line map, one push per ask).
module tb_inst_fetcher;
  logic        clk = 1'b0;
  logic        rst, rdy, has_misbranch, in_has_jump, mem_done, iq_full;
  logic [31:0] in_pc, mem_data;
  logic [31:0] out_inst, mem_addr, iq_inst, iq_pc;
  logic        out_has_ask, mem_req, iq_valid, iq_pred_jump;

`ifdef FETCHER_ICACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  inst_fetcher #(.ICACHE_INDEX_BITS(6)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .has_misbranch(has_misbranch),
    .in_pc(in_pc), .in_has_jump(in_has_jump), .out_inst(out_inst), .out_has_ask(out_has_ask),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .iq_full(iq_full), .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc),
    .iq_pred_jump(iq_pred_jump)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          lat;
    logic        jump;
    logic        hit;   // hit expected when the cache is built in
  } vec_t;

  int total = 0, passed = 0;
  bit mem_auto;
  int mem_lat, req_age;
  logic        s_ask, s_req, s_valid, s_pred, s_rdy, s_mis, s_jump;
  logic [31:0] s_addr, s_out_inst, s_iq_inst, s_iq_pc, s_pc_in;
  logic [31:0] model_line [int];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h0000_0013;
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  function automatic logic model_hit(input logic [31:0] pc);
    logic [31:0] line;
    if (!CACHE || !model_line.exists(idx_of(pc))) return 1'b0;
    line = model_line[idx_of(pc)];
    return line[31:2] == pc[31:2];
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h0;
    return base + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One clock: memory responder, sample on falling edge, then step past the rising edge.
  task automatic cycle();
    if (mem_auto) begin
      mem_done = 1'b0;
      if (mem_req === 1'b1) begin
        req_age++;
        if (req_age >= mem_lat && rdy) begin
          mem_done = 1'b1;
          mem_data = mem_word(mem_addr);
        end
      end else begin
        req_age = 0;
      end
    end
    @(negedge clk);
    s_ask = out_has_ask; s_req = mem_req; s_addr = mem_addr; s_out_inst = out_inst;
    s_valid = iq_valid; s_iq_inst = iq_inst; s_iq_pc = iq_pc; s_pred = iq_pred_jump;
    s_rdy = rdy; s_mis = has_misbranch; s_pc_in = in_pc; s_jump = in_has_jump;
    @(posedge clk);
    #1;
  endtask

  // Starts from IDLE with the pc on in_pc; checks ask latency, miss path, instruction and push.
  task automatic fetch_vec(input vec_t v, input string tag);
    int   ask_at;
    logic got_req, exp_hit;
    in_pc = v.pc; in_has_jump = v.jump; mem_lat = v.lat;
    ask_at = 0; got_req = 1'b0;
    exp_hit = CACHE && v.hit;
    cycle();
    chk({tag, "_idle_nopush"}, {31'b0, s_valid}, 32'd0);
    for (int n = 1; n <= 40 && ask_at == 0; n++) begin
      cycle();
      if (s_req) got_req = 1'b1;
      if (s_ask) ask_at = n;
    end
    chk({tag, "_ask_latency"}, ask_at, exp_hit ? 32'd1 : 32'(v.lat + 1));
    chk({tag, "_mem_req_seen"}, {31'b0, got_req}, {31'b0, !exp_hit});
    chk({tag, "_ask_inst"}, s_out_inst, mem_word(v.pc));
    cycle();
    chk({tag, "_push_valid"}, {31'b0, s_valid}, 32'd1);
    chk({tag, "_push_pc"}, s_iq_pc, v.pc);
    chk({tag, "_push_inst"}, s_iq_inst, mem_word(v.pc));
    chk({tag, "_push_pred"}, {31'b0, s_pred}, {31'b0, v.jump});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    int   ask_cnt;
    logic pending, pending_new, had_req, req_seen, exp_valid;
    logic [31:0] ppc, pinst;

    vecs = '{
      '{32'h000, 5, 1'b0, 1'b0},
      '{32'h000, 2, 1'b1, 1'b1},
      '{32'h100, 3, 1'b0, 1'b0},
      '{32'h000, 1, 1'b1, 1'b0},
      '{32'h104, 4, 1'b0, 1'b0},
      '{32'h104, 2, 1'b1, 1'b1},
      '{32'h004, 2, 1'b0, 1'b0},
      '{32'h004, 3, 1'b1, 1'b1},
      '{32'h100, 1, 1'b1, 1'b0}
    };

    rst = 1'b1; rdy = 1'b1; has_misbranch = 1'b0; in_pc = '0; in_has_jump = 1'b0;
    mem_done = 1'b0; mem_data = '0; iq_full = 1'b0;
    mem_auto = 1'b1; mem_lat = 4; req_age = 0;
    cycle();
    cycle();
    chk("reset_ask", {31'b0, s_ask}, 32'd0);
    chk("reset_mem_req", {31'b0, s_req}, 32'd0);
    chk("reset_iq_valid", {31'b0, s_valid}, 32'd0);
    chk("reset_out_inst", s_out_inst, 32'd0);
    chk("reset_mem_addr", s_addr, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) fetch_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush while waiting on memory, with the response landing in the flush cycle.
    mem_auto = 1'b0; in_pc = 32'h200; in_has_jump = 1'b0;
    cycle();
    cycle();
    chk("flush_req_up", {31'b0, s_req}, 32'd1);
    chk("flush_req_addr", s_addr, 32'h200);
    has_misbranch = 1'b1; mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
    cycle();
    chk("flush_no_push", {31'b0, s_valid}, 32'd0);
    has_misbranch = 1'b0; mem_done = 1'b0; in_pc = 32'h304;
    cycle();
    chk("flush_req_dropped", {31'b0, s_req}, 32'd0);
    chk("flush_no_ask", {31'b0, s_ask}, 32'd0);
    cycle();
    chk("resume_req", {31'b0, s_req}, 32'd1);
    chk("resume_addr", s_addr, 32'h304);
    mem_auto = 1'b1; req_age = 0; mem_lat = 2;
    ask_cnt = 0;
    for (int n = 0; n < 20 && !s_ask; n++) cycle();
    chk("resume_ask", {31'b0, s_ask}, 32'd1);
    chk("resume_inst", s_out_inst, mem_word(32'h304));
    cycle();
    chk("resume_push_pc", s_iq_pc, 32'h304);
    fetch_vec('{32'h200, 2, 1'b0, 1'b0}, "flushed_line_not_filled");

    // Queue full holds the fetcher in IDLE.
    in_pc = 32'h400; iq_full = 1'b1;
    for (int n = 0; n < 10; n++) begin
      cycle();
      chk("full_no_req", {31'b0, s_req}, 32'd0);
      chk("full_no_ask", {31'b0, s_ask}, 32'd0);
    end
    iq_full = 1'b0;
    fetch_vec('{32'h400, 3, 1'b0, 1'b0}, "after_full");

    // Stall during ASK: the ask is held and exactly one push follows.
    in_pc = 32'h504; in_has_jump = 1'b0; mem_lat = 2;
    cycle();
    cycle();
    cycle();
    chk("stall_pre_ask", {31'b0, s_ask}, 32'd0);
    rdy = 1'b0;
    for (int n = 0; n < 3; n++) begin
      cycle();
      if (s_ask) ask_cnt++;
      chk("stall_no_push", {31'b0, s_valid}, 32'd0);
      chk("stall_inst_held", s_out_inst, mem_word(32'h504));
    end
    chk("stall_ask_held", ask_cnt, 32'd3);
    rdy = 1'b1;
    cycle();
    chk("stall_ask_release", {31'b0, s_ask}, 32'd1);
    chk("stall_release_no_push", {31'b0, s_valid}, 32'd0);
    in_has_jump = 1'b1;
    cycle();
    chk("stall_push", {31'b0, s_valid}, 32'd1);
    chk("stall_push_pred", {31'b0, s_pred}, 32'd1);
    chk("stall_push_pc", s_iq_pc, 32'h504);
    chk("stall_push_inst", s_iq_inst, mem_word(32'h504));
    cycle();
    chk("stall_single_push", {31'b0, s_valid}, 32'd0);

    // Randomized run against the transaction-level model, from a clean cache.
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    pending = 1'b0; had_req = 1'b0; req_seen = 1'b0; ppc = '0; pinst = '0;
    in_pc = rand_pc();
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      has_misbranch = ($urandom_range(0, 29) == 0);
      iq_full = ($urandom_range(0, 4) == 0);
      in_has_jump = ($urandom_range(0, 1) != 0);
      if (req_age == 0) mem_lat = $urandom_range(1, 4);
      cycle();
      if (s_req && !req_seen) begin
        req_seen = 1'b1;
        had_req = 1'b1;
        chk("rnd_req_addr", s_addr, s_pc_in);
        chk("rnd_req_on_miss", {31'b0, model_hit(s_pc_in)}, 32'd0);
      end
      if (!s_req) req_seen = 1'b0;
      if (s_rdy) begin
        pending_new = 1'b0;
        if (s_ask) begin
          chk("rnd_ask_single", {31'b0, pending}, 32'd0);
          chk("rnd_ask_inst", s_out_inst, mem_word(s_pc_in));
          if (!had_req) chk("rnd_hit_expected", {31'b0, model_hit(s_pc_in)}, 32'd1);
          if (CACHE) model_line[idx_of(s_pc_in)] = s_pc_in;
          had_req = 1'b0;
          if (!s_mis) begin
            pending_new = 1'b1;
            ppc = s_pc_in;
            pinst = mem_word(s_pc_in);
          end
        end
        exp_valid = pending && !s_mis;
        chk("rnd_push_valid", {31'b0, s_valid}, {31'b0, exp_valid});
        if (exp_valid && s_valid) begin
          chk("rnd_push_pc", s_iq_pc, ppc);
          chk("rnd_push_inst", s_iq_inst, pinst);
          chk("rnd_push_pred", {31'b0, s_pred}, {31'b0, s_jump});
        end
        pending = pending_new;
        if (s_mis) begin
          had_req = 1'b0;
          in_pc = rand_pc();
        end else if (s_ask) begin
          in_pc = rand_pc();
        end
      end else begin
        chk("rnd_frozen_no_push", {31'b0, s_valid}, 32'd0);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
